// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises {addr,~addr,cmd,~cmd} or a repeat frame,
// producing a registered mark/space envelope and a carrier-modulated LED drive.
module ir_nec_tx #(
  parameter int unsigned TICK_DIV    = 15188,
  parameter int unsigned CARRIER_DIV = 711,
  parameter int unsigned CARRIER_HI  = 237,
  parameter int unsigned FRAME_TICKS = 192,
  parameter bit          OUT_INV     = 1'b0
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic [15:0] code,
  input  logic        send,
  input  logic        repeat_req,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        ir_env,
  output logic        ir_out
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CAR_LAST   = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CAR_HI     = CW'(CARRIER_HI);
  localparam logic [7:0]    FRAME_LAST = 8'(FRAME_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_HOLDOFF
  } state_t;

  state_t          r_state, w_state_nx;
  logic [PW-1:0]   r_presc;
  logic [CW-1:0]   r_ccnt, w_ccnt_nx;
  logic [7:0]      r_units;
  logic [4:0]      r_su, r_idx, w_dur;
  logic [31:0]     r_shift;
  logic            r_rep, r_busy, r_done, r_env, r_out;
  logic            w_tick, w_accept, w_end, w_hold_end;
  logic            w_mark_cur, w_mark_nx, w_done_nx, w_out_nx;

  assign w_tick     = (r_state != S_IDLE) && (r_presc == PRESC_LAST);
  assign w_accept   = (r_state == S_IDLE) && (send || repeat_req) && !abort;
  assign w_end      = w_tick && (r_su == w_dur);
  assign w_hold_end = (r_state == S_HOLDOFF) && w_tick && (r_units == FRAME_LAST);

  always_comb begin
    w_dur = '0;
    case (r_state)
      S_LEAD_MARK:  w_dur = 5'd15;
      S_LEAD_SPACE: w_dur = r_rep ? 5'd3 : 5'd7;
      S_BIT_SPACE:  w_dur = r_shift[0] ? 5'd2 : 5'd0;
      default:      w_dur = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:       if (w_accept) w_state_nx = S_LEAD_MARK;
      S_LEAD_MARK:  if (w_end) w_state_nx = S_LEAD_SPACE;
      S_LEAD_SPACE: if (w_end) w_state_nx = r_rep ? S_STOP_MARK : S_BIT_MARK;
      S_BIT_MARK:   if (w_end) w_state_nx = S_BIT_SPACE;
      S_BIT_SPACE:  if (w_end) w_state_nx = (r_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (w_end) w_state_nx = S_HOLDOFF;
      S_HOLDOFF:    if (w_hold_end) w_state_nx = S_IDLE;
      default:      w_state_nx = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_state_nx = S_IDLE;
  end

  // Output logic: next-cycle values so the registered outputs line up with the state
  always_comb begin
    w_mark_cur = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) || (r_state == S_STOP_MARK);
    w_mark_nx  = (w_state_nx == S_LEAD_MARK) || (w_state_nx == S_BIT_MARK) ||
                 (w_state_nx == S_STOP_MARK);
    w_ccnt_nx  = '0;
    if (w_mark_nx && w_mark_cur)
      w_ccnt_nx = (r_ccnt == CAR_LAST) ? '0 : r_ccnt + 1'b1;
    w_out_nx   = (w_mark_nx && (w_ccnt_nx < CAR_HI)) ^ OUT_INV;
    w_done_nx  = w_hold_end && !abort;
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_ccnt  <= '0;
      r_units <= '0;
      r_su    <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_rep   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_env   <= 1'b0;
      r_out   <= OUT_INV;
    end else begin
      if (r_state == S_IDLE || w_state_nx == S_IDLE) begin
        r_presc <= '0;
        r_units <= '0;
      end else begin
        r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
        if (w_tick) r_units <= r_units + 1'b1;
      end
      if (w_state_nx != r_state)                 r_su <= '0;
      else if (w_tick && r_state != S_HOLDOFF)   r_su <= r_su + 1'b1;
      if (w_accept) begin
        r_shift <= {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
        r_idx   <= '0;
        r_rep   <= !send;
      end else if (r_state == S_BIT_SPACE && w_end) begin
        r_shift <= {1'b0, r_shift[31:1]};
        r_idx   <= r_idx + 1'b1;
      end
      r_ccnt <= w_ccnt_nx;
      r_busy <= (w_state_nx != S_IDLE);
      r_done <= w_done_nx;
      r_env  <= w_mark_nx;
      r_out  <= w_out_nx;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign ir_env = r_env;
  assign ir_out = r_out;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed bench for ir_nec_tx with short timing parameters; two instances
// (normal and inverted LED drive) share all inputs.
module tb_ir_nec_tx;
  logic        clk27 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] code = 16'h10EF;
  logic        send = 1'b0, repeat_req = 1'b0, abort = 1'b0;
  logic        busy, done, ir_env, ir_out;
  logic        busy_i, done_i, env_i, ir_out_i;
  int          checks = 0;
  int          errors = 0;
  logic        env_a  [0:1023];
  logic        out_a  [0:1023];
  logic        outi_a [0:1023];
  logic        busy_a [0:1023];
  logic        done_a [0:1023];

  localparam logic [31:0] FRAME_WORD = 32'h10EF_EF10;

  ir_nec_tx #(.TICK_DIV(4), .CARRIER_DIV(6), .CARRIER_HI(2), .FRAME_TICKS(192), .OUT_INV(1'b0)) dut (
    .clk27(clk27), .reset_n(reset_n), .code(code), .send(send), .repeat_req(repeat_req),
    .abort(abort), .busy(busy), .done(done), .ir_env(ir_env), .ir_out(ir_out));

  ir_nec_tx #(.TICK_DIV(4), .CARRIER_DIV(6), .CARRIER_HI(2), .FRAME_TICKS(192), .OUT_INV(1'b1)) dut_inv (
    .clk27(clk27), .reset_n(reset_n), .code(code), .send(send), .repeat_req(repeat_req),
    .abort(abort), .busy(busy_i), .done(done_i), .ir_env(env_i), .ir_out(ir_out_i));

  always #5 clk27 = ~clk27;

  task automatic step();
    @(posedge clk27);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Request at edge 0; sample index c holds the outputs seen after edge c-1.
  task automatic capture(input logic s, input logic r, input logic hold,
                         input int n, input int inj, input int abt);
    for (int c = 0; c < 1024; c++) begin
      env_a[c] = 1'b0; out_a[c] = 1'b0; outi_a[c] = 1'b1; busy_a[c] = 1'b0; done_a[c] = 1'b0;
    end
    send = s;
    repeat_req = r;
    step();
    if (!hold) send = 1'b0;
    repeat_req = 1'b0;
    for (int c = 1; c <= n; c++) begin
      env_a[c] = ir_env; out_a[c] = ir_out; outi_a[c] = ir_out_i;
      busy_a[c] = busy; done_a[c] = done;
      if (!hold) send = (c == inj);
      abort = (c == abt);
      step();
    end
    send = 1'b0;
    abort = 1'b0;
  endtask

  function automatic int env_miss(input int lo, input int hi, input logic v);
    int e = 0;
    for (int c = lo; c <= hi; c++) if (env_a[c] !== v) e++;
    return e;
  endfunction

  function automatic int busy_miss(input int lo, input int hi, input logic v);
    int e = 0;
    for (int c = lo; c <= hi; c++) if (busy_a[c] !== v) e++;
    return e;
  endfunction

  function automatic int done_count(input int lo, input int hi);
    int e = 0;
    for (int c = lo; c <= hi; c++) if (done_a[c] === 1'b1) e++;
    return e;
  endfunction

  // Expected LED drive: 110000 repeating from the first cycle of every mark.
  function automatic int carrier_err(input int n);
    int   e = 0;
    int   p = 0;
    logic x;
    for (int c = 1; c <= n; c++) begin
      if (env_a[c] === 1'b1 && env_a[c-1] !== 1'b1) p = 0;
      else if (env_a[c] === 1'b1) p++;
      x = (env_a[c] === 1'b1) && ((p % 6) < 2);
      if (out_a[c] !== x) e++;
      if (outi_a[c] !== !x) e++;
    end
    return e;
  endfunction

  // Pulse-distance decode of the envelope from the first data mark (cycle 97).
  function automatic logic [31:0] env_decode();
    logic [31:0] w = '0;
    int c = 97;
    int ml, sl;
    for (int i = 0; i < 32; i++) begin
      ml = 0;
      while (c < 1023 && env_a[c] === 1'b1) begin ml++; c++; end
      sl = 0;
      while (c < 1023 && env_a[c] === 1'b0) begin sl++; c++; end
      w[i] = (sl > 8);
      if (ml != 4 || (sl != 4 && sl != 12)) w[i] = 1'bx;
    end
    return w;
  endfunction

  // Receiver model working on the modulated output: a mark starts on a high
  // after at least 5 low cycles; the distance between mark starts gives the bit.
  function automatic logic [15:0] rcv_decode(input int n);
    int          st[$];
    logic [31:0] b = '0;
    logic        quiet;
    int          d;
    for (int c = 1; c <= n; c++) begin
      if (out_a[c] === 1'b1) begin
        quiet = 1'b1;
        for (int k = 1; k <= 5; k++) if (c - k >= 1 && out_a[c-k] === 1'b1) quiet = 1'b0;
        if (quiet) st.push_back(c);
      end
    end
    if (st.size() < 34) return 16'hFFFF;
    if (st[1] - st[0] != 96) return 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      d = st[i+2] - st[i+1];
      if (d == 8) b[i] = 1'b0;
      else if (d == 16) b[i] = 1'b1;
      else return 16'hFFFF;
    end
    if (b[15:8] !== ~b[7:0] || b[31:24] !== ~b[23:16]) return 16'hFFFF;
    return {b[7:0], b[23:16]};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    checks++;
    if ({busy, done, ir_env, ir_out, ir_out_i} !== 5'b00001) begin
      errors++; $display("FAIL reset_outputs: got %b want 00001", {busy, done, ir_env, ir_out, ir_out_i});
    end
    reset_n = 1'b1;
    step();
    step();
    checks++;
    if ({busy_i, done_i, env_i, busy, ir_env, ir_out_i} !== 6'b000001) begin
      errors++; $display("FAIL idle_after_reset: got %b want 000001", {busy_i, done_i, env_i, busy, ir_env, ir_out_i});
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    capture(1'b1, 1'b0, 1'b0, 800, -1, -1);
    checks++;
    if (env_miss(1, 64, 1'b1) != 0) begin errors++; $display("FAIL lead_mark: %0d bad cycles want 0", env_miss(1, 64, 1'b1)); end
    checks++;
    if (env_miss(65, 96, 1'b0) != 0) begin errors++; $display("FAIL lead_space: %0d bad cycles want 0", env_miss(65, 96, 1'b0)); end
    checks++;
    if (env_miss(97, 100, 1'b1) + env_miss(101, 104, 1'b0) != 0) begin
      errors++; $display("FAIL first_bit: %0d bad cycles want 0", env_miss(97, 100, 1'b1) + env_miss(101, 104, 1'b0));
    end
    checks++;
    if (env_decode() !== FRAME_WORD) begin errors++; $display("FAIL env_bits: got %h want %h", env_decode(), FRAME_WORD); end
    checks++;
    if ({env_a[484], env_a[485]} !== 2'b10 || env_miss(485, 800, 1'b0) != 0) begin
      errors++; $display("FAIL last_fall: env484/485=%b%b trailing bad=%0d want 10/0", env_a[484], env_a[485], env_miss(485, 800, 1'b0));
    end
    checks++;
    if (done_a[769] !== 1'b1 || done_count(1, 800) != 1) begin
      errors++; $display("FAIL frame_done: done769=%b pulses=%0d want 1/1", done_a[769], done_count(1, 800));
    end
    checks++;
    if (busy_miss(1, 768, 1'b1) != 0 || busy_a[769] !== 1'b0) begin
      errors++; $display("FAIL frame_busy: bad=%0d busy769=%b want 0/0", busy_miss(1, 768, 1'b1), busy_a[769]);
    end
    checks++;
    if (carrier_err(800) != 0) begin errors++; $display("FAIL frame_carrier: %0d bad samples want 0", carrier_err(800)); end
    checks++;
    if (rcv_decode(800) !== 16'h10EF) begin errors++; $display("FAIL rcv_code: got %h want 10ef", rcv_decode(800)); end
  endtask

  task automatic test_repeat();
    do_reset();
    capture(1'b0, 1'b1, 1'b0, 800, -1, -1);
    checks++;
    if (env_miss(1, 64, 1'b1) + env_miss(65, 80, 1'b0) + env_miss(81, 84, 1'b1) + env_miss(85, 800, 1'b0) != 0) begin
      errors++; $display("FAIL repeat_env: %0d bad cycles want 0",
        env_miss(1, 64, 1'b1) + env_miss(65, 80, 1'b0) + env_miss(81, 84, 1'b1) + env_miss(85, 800, 1'b0));
    end
    checks++;
    if (done_a[769] !== 1'b1 || done_count(1, 800) != 1 || busy_miss(1, 768, 1'b1) != 0 || busy_a[769] !== 1'b0) begin
      errors++; $display("FAIL repeat_done_busy: done769=%b pulses=%0d busybad=%0d busy769=%b want 1/1/0/0",
        done_a[769], done_count(1, 800), busy_miss(1, 768, 1'b1), busy_a[769]);
    end
    checks++;
    if (carrier_err(800) != 0) begin errors++; $display("FAIL repeat_carrier: %0d bad samples want 0", carrier_err(800)); end
  endtask

  task automatic test_priority();
    do_reset();
    capture(1'b1, 1'b1, 1'b0, 800, -1, -1);
    checks++;
    if (env_miss(65, 96, 1'b0) != 0 || env_decode() !== FRAME_WORD) begin
      errors++; $display("FAIL send_priority: space bad=%0d bits=%h want 0/%h", env_miss(65, 96, 1'b0), env_decode(), FRAME_WORD);
    end
  endtask

  task automatic test_ignore_mid();
    do_reset();
    capture(1'b1, 1'b0, 1'b0, 800, 100, -1);
    checks++;
    if (env_decode() !== FRAME_WORD || env_miss(485, 800, 1'b0) != 0 || done_count(1, 800) != 1 || done_a[769] !== 1'b1) begin
      errors++; $display("FAIL ignore_mid_send: bits=%h trail=%0d pulses=%0d done769=%b want %h/0/1/1",
        env_decode(), env_miss(485, 800, 1'b0), done_count(1, 800), done_a[769], FRAME_WORD);
    end
  endtask

  task automatic test_abort();
    do_reset();
    capture(1'b1, 1'b0, 1'b0, 800, -1, 200);
    checks++;
    if (busy_a[200] !== 1'b1 || {env_a[201], busy_a[201]} !== 2'b00) begin
      errors++; $display("FAIL abort_edge: busy200=%b env/busy201=%b%b want 1/00", busy_a[200], env_a[201], busy_a[201]);
    end
    checks++;
    if (env_miss(201, 800, 1'b0) + busy_miss(201, 800, 1'b0) != 0 || done_count(1, 800) != 0) begin
      errors++; $display("FAIL abort_after: bad=%0d pulses=%0d want 0/0",
        env_miss(201, 800, 1'b0) + busy_miss(201, 800, 1'b0), done_count(1, 800));
    end
    send = 1'b1;
    abort = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_over_send: busy=%b want 0", busy); end
    abort = 1'b0;
    step();
    send = 1'b0;
    checks++;
    if ({busy, ir_env} !== 2'b11) begin errors++; $display("FAIL accept_after_abort: busy/env=%b want 11", {busy, ir_env}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    capture(1'b1, 1'b0, 1'b1, 800, -1, -1);
    checks++;
    if (done_a[769] !== 1'b1 || {env_a[769], busy_a[769]} !== 2'b00 || {env_a[770], busy_a[770]} !== 2'b11) begin
      errors++; $display("FAIL back_to_back: done769=%b e/b769=%b%b e/b770=%b%b want 1/00/11",
        done_a[769], env_a[769], busy_a[769], env_a[770], busy_a[770]);
    end
    checks++;
    if (done_count(1, 800) != 1 || env_decode() !== FRAME_WORD) begin
      errors++; $display("FAIL held_send_frame: pulses=%0d bits=%h want 1/%h", done_count(1, 800), env_decode(), FRAME_WORD);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    do_reset();
    send = 1'b1;
    step();
    send = 1'b0;
    repeat (299) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_reset: got %b want 1", busy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ir_env, ir_out, ir_out_i} !== 5'b00001) begin
      errors++; $display("FAIL async_reset: got %b want 00001", {busy, done, ir_env, ir_out, ir_out_i});
    end
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy !== 1'b0 || ir_env !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL no_resume: %0d active cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_repeat();
    test_priority();
    test_ignore_mid();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
